mem_arbiter_rr: RTL
===================

Name: mem_arbiter_rr

Overview:
N-way memory arbiter: the parametrised successor to the fixed two-requester icache/dcache arbiter in the brisc core. Any number of cache-side requesters (I$, D$, future prefetcher/PTW) share the single memory port. Selection is fixed-priority or round-robin, one transaction is in flight at a time, the response is routed back to its owner, and a timeout watchdog covers a stuck memory.

Parameters:
NUM_REQ, 2, number of requesters (2..8); index 0 is highest priority in fixed mode
ADDR_W, 32, address width
LINE_W, 128, cache-line data width
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
TIMEOUT_CYC, 1024, cycles in WAIT before abort; 0 disables the watchdog

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid_in  in  NUM_REQ  per-requester request
req_write_in  in  NUM_REQ  1 = write line, 0 = read line
req_addr_in  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data_in  in  NUM_REQ*LINE_W  packed write data
grant_out  out  NUM_REQ  one-hot owner of the current transaction
mem_req_valid_out  out  1  request to memory
mem_req_write_out  out  1  write flag to memory
mem_req_addr_out  out  ADDR_W  address to memory
mem_req_data_out  out  LINE_W  write data to memory
mem_resp_valid_in  in  1  memory response (read data or write ack)
mem_resp_data_in  in  LINE_W  read data
resp_valid_out  out  NUM_REQ  one-hot one-cycle response pulse to owner
resp_data_out  out  LINE_W  response data, shared by all requesters
resp_err_out  out  1  response is a timeout abort
busy_out  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (reset low, async): state = IDLE; rr_ptr = NUM_REQ-1 (first RR search starts at 0); all outputs 0; timeout counter 0.
- FSM states:
  - IDLE: if any req_valid_in is set, pick a winner. In the same edge, latch its addr/data/write and set grant_out and mem_req_valid_out. Go to ISSUE.
  - ISSUE: mem_req_valid_out = 1 for exactly this one cycle. Go to WAIT. mem_resp_valid_in is ignored here; memory latency is at least 1 cycle.
  - WAIT: mem_req_valid_out = 0. mem_req_addr/data/write_out hold the latched values. grant_out stays held. The counter increments each cycle.
    - On mem_resp_valid_in: register resp_data_out <= mem_resp_data_in; resp_valid_out <= grant_out; resp_err_out <= 0; clear grant_out; go to IDLE.
    - If the counter reaches TIMEOUT_CYC before a response: resp_valid_out <= grant_out; resp_err_out <= 1; resp_data_out <= 0; go to IDLE.
- Latency: request seen in IDLE at cycle 0 → grant and mem_req_valid at cycle 1. Response at cycle k → resp_valid_out at cycle k+1. Earliest next grant is cycle k+2, because IDLE evaluates at k+1.
- Round-robin selection: search from rr_ptr+1 upward, modulo NUM_REQ. On grant, rr_ptr <= winner. Fixed mode: lowest set index wins and rr_ptr is unused.
- Requester drops req_valid after grant: the transaction still completes and the response is still delivered.
- Requester keeps req_valid high after its response: it is eligible again at the next IDLE.
- A late mem_resp_valid_in after a timeout, arriving in IDLE or ISSUE, is dropped.
- resp_valid_out, resp_err_out: single-cycle pulses. resp_data_out holds until the next response.
- Reset asserted mid-transaction: immediate return to IDLE, no response pulse.

Decomposition:
- brisc_pkg additions:
  - arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT}
  - ARB_MAX_REQ = 8
- One sub-module, rr_picker (combinational):
  - inputs: request vector, pointer, mode
  - output: one-hot winner plus winner index
  - implementation: double-width rotate-and-priority-encode

Test Plan:
- NUM_REQ=2, RR: req0 and req1 both high continuously, memory responds 3 cycles after each issue → grants alternate 0,1,0,1; each resp_valid_out pulse goes to the matching owner, 5 cycles between consecutive grants.
- Fixed mode, NUM_REQ=4, req 1/2/3 high continuously → grant always 1; 2 and 3 starved; rr_ptr unchanged.
- Read: req2 addr 0x0000_1040; memory returns 0xDEAD…BEEF after 10 cycles → mem_req_addr_out = 0x1040 for one valid cycle; resp_valid_out = 0b0100; resp_data_out = 0xDEAD…BEEF; resp_err_out = 0.
- TIMEOUT_CYC=16, memory never responds → resp_err_out and resp_valid_out pulse 17 cycles after issue. A late response injected afterwards produces no pulse.
- Reset: pull reset low during WAIT → all outputs 0 asynchronously (before the next clk edge). After release, the first RR grant goes to the lowest requesting index.
- Requester 0 drops req_valid the cycle after grant → mem request still issued once; resp_valid_out[0] still pulses.

Source files
------------

// File: rtl/mem_arbiter_rr_pkg.sv
// rtl/mem_arbiter_rr_pkg.sv - shared types and limits for the N-way memory arbiter
package mem_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam int ARB_MAX_REQ = 8;
  // Requester index field is sized for the largest supported arbiter.
  localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// rtl/mem_arbiter_rr_if.sv - requester, memory and response bundle of the arbiter
interface mem_arbiter_rr_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128
);
  logic [NUM_REQ-1:0]        req_valid_in;
  logic [NUM_REQ-1:0]        req_write_in;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_in;
  logic [NUM_REQ*LINE_W-1:0] req_data_in;
  logic [NUM_REQ-1:0]        grant_out;
  logic                      mem_req_valid_out;
  logic                      mem_req_write_out;
  logic [ADDR_W-1:0]         mem_req_addr_out;
  logic [LINE_W-1:0]         mem_req_data_out;
  logic                      mem_resp_valid_in;
  logic [LINE_W-1:0]         mem_resp_data_in;
  logic [NUM_REQ-1:0]        resp_valid_out;
  logic [LINE_W-1:0]         resp_data_out;
  logic                      resp_err_out;
  logic                      busy_out;

  modport master (
    input  req_valid_in, req_write_in, req_addr_in, req_data_in,
    input  mem_resp_valid_in, mem_resp_data_in,
    output grant_out, mem_req_valid_out, mem_req_write_out,
    output mem_req_addr_out, mem_req_data_out,
    output resp_valid_out, resp_data_out, resp_err_out, busy_out
  );

  modport slave (
    output req_valid_in, req_write_in, req_addr_in, req_data_in,
    output mem_resp_valid_in, mem_resp_data_in,
    input  grant_out, mem_req_valid_out, mem_req_write_out,
    input  mem_req_addr_out, mem_req_data_out,
    input  resp_valid_out, resp_data_out, resp_err_out, busy_out
  );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational round-robin / fixed-priority winner select
module mem_arbiter_rr_picker
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [ARB_IDX_W-1:0] ptr,
  input  logic                 rr_mode,
  output logic [NUM_REQ-1:0]   winner,
  output logic [ARB_IDX_W-1:0] winner_idx,
  output logic                 any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int                   start;
  int                   off;
  int                   sel;

  // Rotate so the search origin lands at bit 0, then take the lowest set bit.
  always_comb begin
    start = 0;
    if (rr_mode) begin
      start = (int'(ptr) + 1) % NUM_REQ;
    end
    dbl = {req, req};
    rot = NUM_REQ'(dbl >> start);
    off = 0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = i;
        any = 1'b1;
      end
    end
    sel        = (start + off) % NUM_REQ;
    winner_idx = ARB_IDX_W'(sel);
    winner     = any ? (NUM_REQ'(1) << sel) : '0;
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-way cache-to-memory arbiter with response routing and watchdog
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic             clk,
  input logic             reset,
  mem_arbiter_rr_if.master bus
);

  localparam bit WDOG_EN = (TIMEOUT_CYC != 0);
  localparam int CNT_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam bit RR_EN   = (RR_MODE != 0);

  arb_state_e           state;
  arb_state_e           state_nxt;
  logic [ARB_IDX_W-1:0] rr_ptr;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [ARB_IDX_W-1:0] pick_idx;
  logic                 any_req;
  logic                 timeout_hit;
  logic [CNT_W-1:0]     wait_cnt;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 write_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LINE_W-1:0]    data_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic                 resp_err_q;
  logic [LINE_W-1:0]    resp_data_q;

  mem_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (bus.req_valid_in),
    .ptr        (rr_ptr),
    .rr_mode    (RR_EN),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any        (any_req)
  );

  assign timeout_hit = WDOG_EN && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE:  if (any_req) state_nxt = ARB_ISSUE;
      ARB_ISSUE: state_nxt = ARB_WAIT;
      ARB_WAIT:  if (bus.mem_resp_valid_in || timeout_hit) state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req_valid_out = (state == ARB_ISSUE);
    bus.busy_out          = (state != ARB_IDLE);
    bus.grant_out         = grant_q;
    bus.mem_req_write_out = write_q;
    bus.mem_req_addr_out  = addr_q;
    bus.mem_req_data_out  = data_q;
    bus.resp_valid_out    = resp_valid_q;
    bus.resp_err_out      = resp_err_q;
    bus.resp_data_out     = resp_data_q;
  end

  // Transaction datapath: latch on grant, route the response back on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= ARB_IDX_W'(NUM_REQ - 1);
      wait_cnt     <= '0;
      grant_q      <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant_q  <= pick_onehot;
            write_q  <= bus.req_write_in[pick_idx];
            addr_q   <= bus.req_addr_in[pick_idx*ADDR_W +: ADDR_W];
            data_q   <= bus.req_data_in[pick_idx*LINE_W +: LINE_W];
            wait_cnt <= '0;
            if (RR_EN) begin
              rr_ptr <= pick_idx;
            end
          end
        end
        ARB_ISSUE: begin
          wait_cnt <= '0;
        end
        ARB_WAIT: begin
          if (bus.mem_resp_valid_in) begin
            resp_valid_q <= grant_q;
            resp_data_q  <= bus.mem_resp_data_in;
            grant_q      <= '0;
          end else if (timeout_hit) begin
            resp_valid_q <= grant_q;
            resp_err_q   <= 1'b1;
            resp_data_q  <= '0;
            grant_q      <= '0;
          end else if (WDOG_EN) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
